score_update_ctrl: RTL
======================

Name: score_update_ctrl

Overview:
Game-side controller that sequences the score accumulator datapath.
- Owns the game state machine.
- Buffers judged hit/miss events from the lane judge in a small FIFO.
- Maintains the live combo and max combo.
- Issues one score update per cycle to the accumulator as a 2-bit input code plus the matching combo value. Drives 00 when idle.
- Pulses the accumulator's clear at game start.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of two, >=2
COMBO_W, 8, combo counter width; saturates at all-ones

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  begin/restart game (IDLE or DONE only)
pause  in  1  PLAY->PAUSE request
resume  in  1  PAUSE->PLAY request
song_end  in  1  chart finished; drain then finish
hit_valid  in  1  judged event valid
hit_ready  out  1  event accepted when hit_valid&&hit_ready
hit_lanes  in  2  lanes hit this beat (bit0 lane A, bit1 lane B)
hit_miss  in  1  event is a miss; hit_lanes ignored when set
game_state  out  2  IDLE=00 PLAY=01 PAUSE=10 DONE=11
score_clr  out  1  one-cycle clear pulse to accumulator
score_inp  out  2  update code to accumulator; 00 = no update
score_combo  out  COMBO_W  combo accompanying score_inp
combo  out  COMBO_W  live combo
max_combo  out  COMBO_W  best combo this game

Behaviour:
Reset and registered outputs
- Reset (async): state IDLE, FIFO empty, end_pending=0, all outputs 0.
- Reset mid-game discards all queued events.
- All outputs are registered except hit_ready.

hit_ready
- hit_ready = !full && (PLAY||PAUSE) && !end_pending, using registered full.
- Events can be accepted while paused; they are held until resume.

State machine
- IDLE: start -> PLAY. Transition cycle clears FIFO, combo, max_combo and end_pending, and sets score_clr=1 for exactly one cycle.
- PLAY: song_end sets end_pending. Otherwise pause -> PAUSE. song_end has priority over pause in the same cycle.
- PLAY: when end_pending && FIFO empty && no pop this cycle -> DONE.
- PAUSE: resume -> PLAY. song_end while paused sets end_pending, stays PAUSE, and exits only via resume.
- DONE: start -> PLAY, with the same clears as from IDLE.
- start is ignored in PLAY and PAUSE; pause/resume are ignored outside their states.

Drain (PLAY only, one pop per cycle)
- Miss event: combo<=0; score_inp=00.
- Hit event, lanes!=00: combo<=sat(combo+1); score_inp=lanes; score_combo=new combo; max_combo<=max(max_combo, new combo).
- Hit event, lanes=00: popped, no effect.
- score_inp/score_combo are valid for exactly one cycle per popped event, then return to 0.

Timing and boundaries
- Latency with empty FIFO in PLAY: event accepted at edge E; score_inp appears after edge E+2. Back-to-back accepted events give back-to-back updates.
- Push and pop in the same cycle are both legal; count is unchanged.
- Push when full cannot occur, because hit_ready is low.
- Combo saturates at 2^COMBO_W-1 and never wraps.

Optional Feature:
FULL_COMBO_BONUS_EN
- Defined: the controller tracks any_miss and any_hit per game. On the PLAY->DONE transition, if !any_miss && any_hit, it issues one extra update (score_inp=11, score_combo=final combo) in the first DONE cycle.
- Undefined: no bonus update is issued and the tracking flags are absent.

Decomposition:
- Package score_pkg: game-state encodings (IDLE/PLAY/PAUSE/DONE), score_inp codes, packed event typedef {miss, lanes[1:0]}, COMBO_W default.
- One sub-module, hit_event_fifo: synchronous FIFO of event typedef with push/pop/full/empty, parameterised by FIFO_DEPTH.

Test Plan:
- Reset mid-PLAY with 3 events queued -> state IDLE, hit_ready=0, score_inp=00, combo=0; events lost after start.
- start; hits lanes 01,10,11 on consecutive cycles -> score_inp 01,10,11 on consecutive cycles with score_combo 1,2,3; score_clr pulse 1 cycle; max_combo=3.
- combo=5, miss event -> combo=0, score_inp=00 that cycle; next hit 01 gives score_combo=1; max_combo stays 5.
- Pause, push 5 events with DEPTH=4 -> hit_ready low after 4; resume -> 4 updates in 4 cycles, 5th accepted once space frees.
- song_end with 2 queued, pause same cycle -> stays PLAY, 2 updates drain, then game_state=11; hit_ready=0 from cycle after song_end.
- COMBO_W=8, 256 hits -> score_combo holds 255; with FULL_COMBO_BONUS_EN -> extra score_inp=11, score_combo=255 in first DONE cycle.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score update controller.
//   game_state_e : game FSM encoding (IDLE=00 PLAY=01 PAUSE=10 DONE=11)
//   INP_*        : accumulator update codes
//   hit_event_t  : judged event as buffered in the event FIFO
package score_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPlay  = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } game_state_e;

    localparam logic [1:0] INP_NONE  = 2'b00;
    localparam logic [1:0] INP_BONUS = 2'b11;

    typedef struct packed {
        logic       miss;
        logic [1:0] lanes;
    } hit_event_t;

    localparam int unsigned COMBO_W_DEFAULT = 8;

endpackage

// File: rtl/hit_event_fifo.sv
// Synchronous FIFO of judged hit events.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   flush       : synchronous clear of all entries
//   push, wdata : write an event (ignored when full)
//   pop, rdata  : rdata shows the oldest entry; pop discards it (ignored when empty)
//   full, empty : occupancy flags derived from the registered count
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module hit_event_fifo
    import score_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  hit_event_t wdata,
    input  logic       pop,
    output hit_event_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned     PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]  CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    hit_event_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == DEPTH_CNT);
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/score_update_ctrl.sv
// Game-side controller sequencing the score accumulator.
// Buffers judged events, drains one per cycle in PLAY, keeps combo / max combo,
// and issues a 2-bit update code plus combo to the accumulator.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   start/pause/resume       : game control requests
//   song_end                 : chart finished; drain queued events, then DONE
//   hit_valid/ready/lanes/miss : judged event handshake (hit_ready is combinational)
//   game_state               : IDLE=00 PLAY=01 PAUSE=10 DONE=11
//   score_clr                : one-cycle accumulator clear at game start
//   score_inp, score_combo   : one update per popped hit event, 00 otherwise
//   combo, max_combo         : live and best combo of this game
// Build option: FULL_COMBO_BONUS_EN adds a bonus update (code 11) in the first
// DONE cycle when the game had hits and no misses.
module score_update_ctrl
    import score_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COMBO_W    = COMBO_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               resume,
    input  logic               song_end,
    input  logic               hit_valid,
    output logic               hit_ready,
    input  logic [1:0]         hit_lanes,
    input  logic               hit_miss,
    output logic [1:0]         game_state,
    output logic               score_clr,
    output logic [1:0]         score_inp,
    output logic [COMBO_W-1:0] score_combo,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo
);

    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_ONE = COMBO_W'(1);

    game_state_e        r_state, w_state_nxt;
    logic               r_end_pending, w_end_pending_nxt;
    hit_event_t         r_ev;
    logic               r_ev_vld;
    hit_event_t         w_fifo_wdata;
    hit_event_t         w_fifo_rdata;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic [COMBO_W-1:0] r_combo, w_combo_nxt;
    logic [COMBO_W-1:0] r_max_combo, w_max_combo_nxt;
    logic [COMBO_W-1:0] w_combo_inc;
    logic               r_score_clr, w_score_clr_nxt;
    logic [1:0]         r_score_inp, w_score_inp_nxt;
    logic [COMBO_W-1:0] r_score_combo, w_score_combo_nxt;
`ifdef FULL_COMBO_BONUS_EN
    logic               r_any_miss, w_any_miss_nxt;
    logic               r_any_hit, w_any_hit_nxt;
`endif

    assign hit_ready = !w_fifo_full && !r_end_pending
                       && ((r_state == StPlay) || (r_state == StPause));
    assign w_push       = hit_valid && hit_ready;
    assign w_pop        = (r_state == StPlay) && !w_fifo_empty;
    assign w_fifo_wdata = {hit_miss, hit_lanes};
    assign w_combo_inc  = (r_combo == COMBO_MAX) ? r_combo : r_combo + COMBO_ONE;

    hit_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(w_flush),
        .push (w_push),
        .wdata(w_fifo_wdata),
        .pop  (w_pop),
        .rdata(w_fifo_rdata),
        .full (w_fifo_full),
        .empty(w_fifo_empty)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_end_pending_nxt = r_end_pending;
        w_flush           = 1'b0;
        w_combo_nxt       = r_combo;
        w_max_combo_nxt   = r_max_combo;
        w_score_clr_nxt   = 1'b0;
        w_score_inp_nxt   = INP_NONE;
        w_score_combo_nxt = '0;
`ifdef FULL_COMBO_BONUS_EN
        w_any_miss_nxt    = r_any_miss;
        w_any_hit_nxt     = r_any_hit;
`endif

        // The event popped last cycle is applied now, even if the game paused meanwhile.
        if (r_ev_vld) begin
            if (r_ev.miss) begin
                w_combo_nxt = '0;
`ifdef FULL_COMBO_BONUS_EN
                w_any_miss_nxt = 1'b1;
`endif
            end else if (r_ev.lanes != 2'b00) begin
                w_combo_nxt       = w_combo_inc;
                w_score_inp_nxt   = r_ev.lanes;
                w_score_combo_nxt = w_combo_inc;
                if (w_combo_inc > r_max_combo) w_max_combo_nxt = w_combo_inc;
`ifdef FULL_COMBO_BONUS_EN
                w_any_hit_nxt = 1'b1;
`endif
            end
        end

        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_nxt       = StPlay;
                    w_flush           = 1'b1;
                    w_end_pending_nxt = 1'b0;
                    w_combo_nxt       = '0;
                    w_max_combo_nxt   = '0;
                    w_score_clr_nxt   = 1'b1;
`ifdef FULL_COMBO_BONUS_EN
                    w_any_miss_nxt    = 1'b0;
                    w_any_hit_nxt     = 1'b0;
`endif
                end
            end
            StPlay: begin
                if (song_end) begin
                    w_end_pending_nxt = 1'b1;
                end else if (pause) begin
                    w_state_nxt = StPause;
                end
                // Wait for the output stage too, so the last update precedes DONE.
                if (r_end_pending && w_fifo_empty && !w_pop && !r_ev_vld) begin
                    w_state_nxt = StDone;
`ifdef FULL_COMBO_BONUS_EN
                    if (!r_any_miss && r_any_hit) begin
                        w_score_inp_nxt   = INP_BONUS;
                        w_score_combo_nxt = r_combo;
                    end
`endif
                end
            end
            StPause: begin
                if (song_end) w_end_pending_nxt = 1'b1;
                if (resume)   w_state_nxt = StPlay;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_end_pending <= 1'b0;
            r_ev          <= '0;
            r_ev_vld      <= 1'b0;
            r_combo       <= '0;
            r_max_combo   <= '0;
            r_score_clr   <= 1'b0;
            r_score_inp   <= INP_NONE;
            r_score_combo <= '0;
`ifdef FULL_COMBO_BONUS_EN
            r_any_miss    <= 1'b0;
            r_any_hit     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_end_pending <= w_end_pending_nxt;
            r_ev_vld      <= w_pop;
            if (w_pop) r_ev <= w_fifo_rdata;
            r_combo       <= w_combo_nxt;
            r_max_combo   <= w_max_combo_nxt;
            r_score_clr   <= w_score_clr_nxt;
            r_score_inp   <= w_score_inp_nxt;
            r_score_combo <= w_score_combo_nxt;
`ifdef FULL_COMBO_BONUS_EN
            r_any_miss    <= w_any_miss_nxt;
            r_any_hit     <= w_any_hit_nxt;
`endif
        end
    end

    assign game_state  = r_state;
    assign score_clr   = r_score_clr;
    assign score_inp   = r_score_inp;
    assign score_combo = r_score_combo;
    assign combo       = r_combo;
    assign max_combo   = r_max_combo;

endmodule
